// File: rtl/aes_pkg.sv
// Shared AES package: block/state types, inverse S-box and GF(2^8) helpers.
// Serves both the encrypt and decrypt datapaths.
package aes_pkg;

  // 128-bit block, byte 0 in bits [127:120]
  typedef logic [127:0] aes_block_t;

  // 4x4 byte state indexed [column][row]; [0][0] is byte 0 (MSB side),
  // so a block casts directly to the column-major FIPS-197 layout
  typedef logic [0:3][0:3][7:0] aes_state_t;

  // Decrypt controller states
  typedef enum logic {
    DEC_IDLE = 1'b0,
    DEC_RUN  = 1'b1
  } dec_fsm_t;

  // Low byte of the field polynomial x^8+x^4+x^3+x+1 (0x11B)
  localparam logic [7:0] AES_POLY = 8'h1B;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  // Multiply by x in GF(2^8)
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  // General GF(2^8) multiply; with a constant operand this folds to XOR trees
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
// last=1 skips InvMixColumns for the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  aes_block_t state,
  input  aes_block_t round_key,
  input  logic       last,
  output aes_block_t result
);

  aes_state_t s;
  aes_state_t k;
  aes_state_t sub;
  aes_state_t mix;

  assign s = state;
  assign k = round_key;

  // Row r rotates right by r columns, then substitution and key add
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sub[c][r] = inv_sbox(s[(c + 4 - r) % 4][r]) ^ k[c][r];
    end
  end

  // InvMixColumns with coefficients {0e,0b,0d,09}
  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mix[c][0] = gf_mul(sub[c][0], 8'h0e) ^ gf_mul(sub[c][1], 8'h0b) ^
                       gf_mul(sub[c][2], 8'h0d) ^ gf_mul(sub[c][3], 8'h09);
    assign mix[c][1] = gf_mul(sub[c][0], 8'h09) ^ gf_mul(sub[c][1], 8'h0e) ^
                       gf_mul(sub[c][2], 8'h0b) ^ gf_mul(sub[c][3], 8'h0d);
    assign mix[c][2] = gf_mul(sub[c][0], 8'h0d) ^ gf_mul(sub[c][1], 8'h09) ^
                       gf_mul(sub[c][2], 8'h0e) ^ gf_mul(sub[c][3], 8'h0b);
    assign mix[c][3] = gf_mul(sub[c][0], 8'h0b) ^ gf_mul(sub[c][1], 8'h0d) ^
                       gf_mul(sub[c][2], 8'h09) ^ gf_mul(sub[c][3], 8'h0e);
  end

  assign result = last ? aes_block_t'(sub) : aes_block_t'(mix);

endmodule

// File: rtl/aes_decrypt.sv
// Iterative AES inverse cipher (AES-128/192/256 by Nk), one round per clock.
// Optional build macro AES_DECRYPT_LOAD_ABORT_EN: load while running aborts
// the current block and restarts with the new ciphertext.
//
// Handshake: load is a request sampled on any rising edge while idle (busy=0);
// loads seen while busy are ignored (or restart the block with the macro).
// valid is a single-cycle pulse marking the edge pt was updated; pt then
// holds until the next block completes.
module aes_decrypt
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] k_sch [0:Nr],
  input  logic         load,
  input  logic [127:0] ct,
  output logic [127:0] pt,
  output logic         valid,
  output logic         busy
);

  localparam int RW = $clog2(Nr + 1);
  localparam logic [RW-1:0] RND_START = RW'(Nr - 1);

  dec_fsm_t   fsm;
  logic [RW-1:0] rnd;
  aes_block_t state;
  aes_block_t round_out;
  logic       abort;

`ifdef AES_DECRYPT_LOAD_ABORT_EN
  assign abort = load;
`else
  assign abort = 1'b0;
`endif

  aes_inv_round u_round (
    .state     (state),
    .round_key (k_sch[rnd]),
    .last      (rnd == '0),
    .result    (round_out)
  );

  // Control FSM, round counter and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm   <= DEC_IDLE;
      rnd   <= '0;
      state <= '0;
      pt    <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (fsm)
        DEC_IDLE: begin
          if (load) begin
            state <= ct ^ k_sch[Nr];
            rnd   <= RND_START;
            fsm   <= DEC_RUN;
            busy  <= 1'b1;
          end
        end
        DEC_RUN: begin
          if (abort) begin
            state <= ct ^ k_sch[Nr];
            rnd   <= RND_START;
          end else if (rnd != '0) begin
            state <= round_out;
            rnd   <= rnd - RW'(1);
          end else begin
            pt    <= round_out;
            valid <= 1'b1;
            fsm   <= DEC_IDLE;
            busy  <= 1'b0;
          end
        end
        default: fsm <= DEC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt.sv
// Bench for aes_decrypt: three instances (AES-128/192/256) driven in parallel.
// A reference AES encryptor with an S-box derived from field arithmetic
// produces ciphertexts; a cycle-level model predicts busy/valid/pt.
module tb_aes_decrypt;

  localparam int NK_OF [3] = '{4, 6, 8};
  localparam int NR_OF [3] = '{10, 12, 14};
`ifdef AES_DECRYPT_LOAD_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  initial forever #5 clk = ~clk;

  logic         load   [3];
  logic [127:0] ct     [3];
  logic [127:0] exp_in [3];
  logic [127:0] pt     [3];
  logic         valid  [3];
  logic         busy   [3];

  logic [127:0] ks_all [3][0:14];
  logic [127:0] ks4 [0:10];
  logic [127:0] ks6 [0:12];
  logic [127:0] ks8 [0:14];

  always_comb for (int r = 0; r <= 10; r++) ks4[r] = ks_all[0][r];
  always_comb for (int r = 0; r <= 12; r++) ks6[r] = ks_all[1][r];
  always_comb for (int r = 0; r <= 14; r++) ks8[r] = ks_all[2][r];

  aes_decrypt #(.Nk(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .k_sch(ks4), .load(load[0]), .ct(ct[0]),
    .pt(pt[0]), .valid(valid[0]), .busy(busy[0]));
  aes_decrypt #(.Nk(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .k_sch(ks6), .load(load[1]), .ct(ct[1]),
    .pt(pt[1]), .valid(valid[1]), .busy(busy[1]));
  aes_decrypt #(.Nk(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .k_sch(ks8), .load(load[2]), .ct(ct[2]),
    .pt(pt[2]), .valid(valid[2]), .busy(busy[2]));

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input int i, input logic [127:0] act,
                       input logic [127:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s nk=%0d actual=%h expected=%h t=%0t", name, NK_OF[i], act, exp, $time);
    end
  endtask

  // ---------------- reference AES (encrypt side) ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] x;
    logic [7:0] y;
    logic [7:0] p;
    x = {1'b0, a};
    y = b;
    p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x[7:0];
      x = x << 1;
      if (x[8]) x = x ^ 9'h11B;
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  // Key schedule for instance i; key is left-justified in 256 bits
  task automatic expand(input int i, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    int nk;
    int nr;
    nk = NK_OF[i];
    nr = NR_OF[i];
    rcon = 8'h01;
    for (int j = 0; j < nk; j++) w[j] = key[255 - 32*j -: 32];
    for (int j = nk; j < 4*(nr+1); j++) begin
      t = w[j-1];
      if (j % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gm(rcon, 8'h02);
      end else if (nk > 6 && j % nk == 4) begin
        t = subw(t);
      end
      w[j] = w[j-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) ks_all[i][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_enc(input int i, input logic [127:0] p);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] x;
    x = p ^ ks_all[i][0];
    for (int r = 1; r <= NR_OF[i]; r++) begin
      for (int k = 0; k < 16; k++) s[k] = x[127 - 8*k -: 8];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          t[4*c+rr] = sb[s[4*((c+rr)%4)+rr]];
      if (r != NR_OF[i]) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          t[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      end
      for (int k = 0; k < 16; k++) x[127 - 8*k -: 8] = t[k];
      x = x ^ ks_all[i][r];
    end
    return x;
  endfunction

  // ---------------- cycle model + scoreboard ----------------
  bit           m_busy  [3];
  bit           m_valid [3];
  logic [127:0] m_pt    [3];
  int           m_cnt   [3];
  logic [127:0] exp_q   [3][$];

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_busy[i] = 1'b0; m_valid[i] = 1'b0; m_pt[i] = '0; m_cnt[i] = 0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!rst_n) begin
          m_busy[i] = 1'b0; m_valid[i] = 1'b0; m_pt[i] = '0; m_cnt[i] = 0;
          exp_q[i].delete();
        end else begin
          m_valid[i] = 1'b0;
          if (!m_busy[i]) begin
            if (load[i]) begin
              m_busy[i] = 1'b1;
              m_cnt[i]  = NR_OF[i];
              exp_q[i].push_back(exp_in[i]);
            end
          end else if (ABORT_EN && load[i]) begin
            m_cnt[i] = NR_OF[i];
            void'(exp_q[i].pop_front());
            exp_q[i].push_back(exp_in[i]);
          end else begin
            m_cnt[i]--;
            if (m_cnt[i] == 0) begin
              m_busy[i]  = 1'b0;
              m_valid[i] = 1'b1;
              m_pt[i]    = exp_q[i].pop_front();
            end
          end
        end
      end
    end
  end

  // Compare every cycle, away from the active edge
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        check("busy", i, 128'(busy[i]), 128'(m_busy[i]));
        check("valid", i, 128'(valid[i]), 128'(m_valid[i]));
        check("pt", i, pt[i], m_pt[i]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [255:0] rand256();
    return {rand128(), rand128()};
  endfunction

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (busy[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", i, 128'(busy[i]), 128'(0));
  endtask

  // Known-answer vector: literal plaintext, latency and single pulse
  task automatic fips(input int i, input logic [255:0] key, input logic [127:0] c_lit);
    logic [127:0] p_lit;
    int seen;
    int pulses;
    p_lit = 128'h00112233445566778899aabbccddeeff;
    expand(i, key);
    check("model_ct", i, aes_enc(i, p_lit), c_lit);
    ct[i] = c_lit; exp_in[i] = p_lit; load[i] = 1'b1;
    seen = -1; pulses = 0;
    for (int n = 1; n <= NR_OF[i] + 6; n++) begin
      @(negedge clk);
      if (n == 1) load[i] = 1'b0;
      if (valid[i]) begin
        pulses++;
        if (seen < 0) seen = n;
      end
    end
    check("kat_latency", i, 128'(seen - 1), 128'(NR_OF[i]));
    check("kat_pulses", i, 128'(pulses), 128'(1));
    check("kat_pt", i, pt[i], p_lit);
  endtask

  task automatic rt(input int i);
    logic [127:0] p;
    for (int b = 0; b < 1000; b++) begin
      p = rand128();
      wait_idle(i);
      expand(i, rand256());
      ct[i] = aes_enc(i, p); exp_in[i] = p; load[i] = 1'b1;
      repeat ($urandom_range(1, 2)) @(negedge clk);
      load[i] = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle(i);
  endtask

  initial begin
    #800us;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] pb [3];
    logic [127:0] cb [3];
    int pulses;
    int last_n;
    int at;
    logic [127:0] got;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load[i] = 1'b0; ct[i] = '0; exp_in[i] = '0;
    end
    build_sbox();
    for (int i = 0; i < 3; i++) expand(i, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("rst_busy", i, 128'(busy[i]), 128'(0));
      check("rst_valid", i, 128'(valid[i]), 128'(0));
      check("rst_pt", i, pt[i], 128'(0));
    end

    fips(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
         128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    fips(1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
         128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    fips(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
         128'h8ea2b7ca516745bfeafc49904b496089);

`ifndef AES_DECRYPT_LOAD_ABORT_EN
    // load held high: three blocks, valid pulses 11 cycles apart
    expand(0, rand256());
    for (int b = 0; b < 3; b++) begin
      pb[b] = rand128(); cb[b] = aes_enc(0, pb[b]);
    end
    ct[0] = cb[0]; exp_in[0] = pb[0]; load[0] = 1'b1;
    pulses = 0; last_n = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (valid[0]) begin
        check("b2b_pt", 0, pt[0], pb[pulses % 3]);
        if (pulses == 0) check("b2b_first", 0, 128'(n - 1), 128'(10));
        else check("b2b_gap", 0, 128'(n - last_n), 128'(11));
        last_n = n;
        pulses++;
      end
      if (n == 1)  begin ct[0] = cb[1]; exp_in[0] = pb[1]; end
      if (n == 12) begin ct[0] = cb[2]; exp_in[0] = pb[2]; end
      if (n == 23) load[0] = 1'b0;
    end
    check("b2b_pulses", 0, 128'(pulses), 128'(3));
`endif

    // load pulsed mid-run
    expand(0, rand256());
    pb[0] = rand128(); cb[0] = aes_enc(0, pb[0]);
    pb[1] = rand128(); cb[1] = aes_enc(0, pb[1]);
    ct[0] = cb[0]; exp_in[0] = pb[0]; load[0] = 1'b1;
    pulses = 0; at = -1; got = '0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) load[0] = 1'b0;
      if (n == 4) begin ct[0] = cb[1]; exp_in[0] = pb[1]; load[0] = 1'b1; end
      if (n == 5) load[0] = 1'b0;
      if (valid[0]) begin pulses++; at = n; got = pt[0]; end
    end
    check("midrun_pulses", 0, 128'(pulses), 128'(1));
`ifdef AES_DECRYPT_LOAD_ABORT_EN
    check("abort_latency", 0, 128'(at - 5), 128'(10));
    check("abort_pt", 0, got, pb[1]);
`else
    check("ignore_latency", 0, 128'(at - 1), 128'(10));
    check("ignore_pt", 0, got, pb[0]);
`endif

    // reset asserted mid-run
    expand(0, rand256());
    pb[0] = rand128();
    ct[0] = aes_enc(0, pb[0]); exp_in[0] = pb[0]; load[0] = 1'b1;
    pulses = 0;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      if (n == 1) load[0] = 1'b0;
      if (n == 5) rst_n = 1'b0;
      if (n == 6) begin
        check("midrst_busy", 0, 128'(busy[0]), 128'(0));
        check("midrst_valid", 0, 128'(valid[0]), 128'(0));
        check("midrst_pt", 0, pt[0], 128'(0));
        rst_n = 1'b1;
      end
      if (n >= 6 && valid[0]) pulses++;
    end
    check("midrst_no_valid", 0, 128'(pulses), 128'(0));

    // randomized round trip on all three key sizes at once
    fork
      rt(0);
      rt(1);
      rt(2);
    join

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
